fdc_seek_ctrl: RTL
==================

// Module: fdc_seek_ctrl
// PURPOSE
// Type-I command sequencer for the virtual floppy drive model. It accepts
// RESTORE, SEEK, STEP-IN and STEP-OUT requests from the FDC register block. It
// controls motor spin-up, generates step pulses and waits for head settle by
// watching drive ready. It also turns the motor off after a number of idle
// index pulses. It sits between the FDC command decoder and one floppy
// instance.
// PARAMETERS
// STEP_PULSE_CYCLES  4        step_in/step_out high time in clk cycles (>=2)
// MAX_STEPS          255      step budget per command before seek_err
// READY_TIMEOUT      24'hFFFFFF  cycles to wait for ready before not_ready error
// MOTOR_OFF_INDEX    10       idle index pulses before motor_on drops
// PORTS
// clk         in   1  system clock
// reset_n     in   1  asynchronous active-low reset
// cmd_valid   in   1  command request; accepted when cmd_valid && cmd_ready
// cmd_ready   out  1  high only in IDLE
// cmd_op      in   2  0=RESTORE 1=SEEK 2=STEP_IN(toward 0) 3=STEP_OUT(toward max)
// cmd_target  in   8  SEEK destination track (ignored for other ops)
// fd_track    in   8  current head track from drive
// fd_ready    in   1  drive ready (spinning, head not stepping)
// fd_index    in   1  drive index signal, active-low pulse
// step_in     out  1  step toward track 0
// step_out    out  1  step toward higher tracks
// motor_on    out  1  spindle motor request
// busy        out  1  command in progress (~cmd_ready)
// done        out  1  one-cycle pulse on command completion
// track0      out  1  fd_track==0, registered
// seek_err    out  1  last command exhausted MAX_STEPS; held until next accept
// not_ready   out  1  last command timed out waiting ready; held until next accept
// BEHAVIOUR
// - Reset: state=IDLE, cmd_ready=1, all other outputs 0, counters 0.
// - States: IDLE -> SPINUP -> COMPARE -> PULSE -> SETTLE -> COMPARE ... -> DONE -> IDLE.
// - IDLE: on accept, latch cmd_op and cmd_target. Clear seek_err and not_ready.
//   Set motor_on=1, step_cnt=0, tmo=0. Go to SPINUP next cycle.
// - SPINUP: if fd_ready, go to COMPARE. Else tmo++.
//   At tmo==READY_TIMEOUT, set not_ready=1 and go to DONE.
// - COMPARE: choose a direction.
//   RESTORE: fd_track==0 -> DONE, else dir=in.
//   SEEK: equal -> DONE; target<fd_track -> in; target>fd_track -> out.
//   STEP_*: issue exactly one step, then DONE on next COMPARE.
//   If step_cnt==MAX_STEPS and not finished, set seek_err=1 and go to DONE.
//   This covers a target beyond the drive's last track, where the track saturates.
// - PULSE: drive the selected step line high for STEP_PULSE_CYCLES cycles.
//   Increment step_cnt (8-bit, saturating). Clear tmo. Go to SETTLE.
// - SETTLE: require 1 cycle with fd_ready==0 or a 2-cycle minimum dwell, then wait fd_ready==1.
//   fd_ready==1 -> COMPARE. Same READY_TIMEOUT rule as SPINUP.
// - DONE: done=1 for one cycle, go to IDLE. step_in and step_out are never high
//   at the same time, and both are low outside PULSE.
// - Motor-off: in IDLE, count fd_index falling edges. Use a synchronized
//   previous-value register, reset to 1. At MOTOR_OFF_INDEX edges, motor_on=0.
//   An accept resets the count. Index edges outside IDLE are ignored.
// - A command accepted while motor_on is already 1 still passes through SPINUP.
//   With fd_ready=1 it exits in 1 cycle.
// - track0 updates every cycle from fd_track, including in IDLE.
// - cmd_valid while busy is ignored (no queueing). Reset mid-command aborts
//   immediately: step lines low, motor off, no done.
// TESTING
// - RESTORE from fd_track=5, ready model settles 10 cycles after each pulse:
//   expect 5 step_in pulses, done once, track0=1, seek_err=0.
// - SEEK target=20 from track 17: expect 3 step_out pulses, each 4 cycles wide, then done.
//   SEEK target=17 from 17: expect done with 0 pulses.
// - SEEK target=100 with the drive saturating at 84: expect 255 step_out pulses,
//   then seek_err=1 and done.
// - fd_ready held 0 during SPINUP (READY_TIMEOUT=100 in bench):
//   expect not_ready=1, done, 0 step pulses.
// - Idle after a command with 10 index pulses: motor_on falls on the 10th falling edge.
//   A new cmd accepted after 5 pulses keeps motor_on=1.
// - Assert reset_n=0 mid-PULSE: step_out and motor_on go 0 asynchronously.
//   After release, cmd_ready=1 with no done pulse.

Source files
------------

// File: rtl/fdc_seek_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fdc_seek_ctrl
//  Brief    : Type-I command sequencer (RESTORE / SEEK / STEP-IN / STEP-OUT)
//             for the virtual floppy drive. Handles motor spin-up, step pulse
//             generation, head-settle wait and idle motor shut-off driven by
//             index pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module fdc_seek_ctrl #(
   parameter int unsigned STEP_PULSE_CYCLES = 4,
   parameter int unsigned MAX_STEPS         = 255,
   parameter logic [23:0] READY_TIMEOUT     = 24'hFFFFFF,
   parameter int unsigned MOTOR_OFF_INDEX   = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [1:0] cmd_op_i,
   input  logic [7:0] cmd_target_i,
   input  logic [7:0] fd_track_i,
   input  logic       fd_ready_i,
   input  logic       fd_index_i,
   output logic       step_in_o,
   output logic       step_out_o,
   output logic       motor_on_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       track0_o,
   output logic       seek_err_o,
   output logic       not_ready_o
);

   // Command opcodes
   localparam logic [1:0] c_op_restore  = 2'd0;
   localparam logic [1:0] c_op_seek     = 2'd1;
   localparam logic [1:0] c_op_step_in  = 2'd2;

   // Counter sizing
   localparam int unsigned c_pw = (STEP_PULSE_CYCLES > 1) ? $clog2(STEP_PULSE_CYCLES) : 1;
   localparam logic [c_pw-1:0] c_pulse_last = c_pw'(STEP_PULSE_CYCLES - 1);
   localparam int unsigned c_iw = $clog2(MOTOR_OFF_INDEX + 1);
   localparam logic [c_iw-1:0] c_idx_last = c_iw'(MOTOR_OFF_INDEX - 1);
   localparam logic [7:0] c_max_steps = 8'(MAX_STEPS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SPINUP  = 3'd1,
      S_COMPARE = 3'd2,
      S_PULSE   = 3'd3,
      S_SETTLE  = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t           state_q,      state_d;
   logic [1:0]       op_q,         op_d;
   logic [7:0]       target_q,     target_d;
   logic             dir_out_q,    dir_out_d;
   logic [7:0]       step_cnt_q,   step_cnt_d;
   logic [23:0]      tmo_q,        tmo_d;
   logic [c_pw-1:0]  pulse_cnt_q,  pulse_cnt_d;
   logic             dwell_q,      dwell_d;
   logic             armed_q,      armed_d;
   logic             stepped_q,    stepped_d;
   logic             motor_q,      motor_d;
   logic             seek_err_q,   seek_err_d;
   logic             not_ready_q,  not_ready_d;
   logic [c_iw-1:0]  idx_cnt_q,    idx_cnt_d;
   logic             idx_sync_q;
   logic             idx_prev_q;
   logic             track0_q;

   logic             cmp_done;
   logic             cmp_out;
   logic             idx_fall;

   // Index falling edge seen after the synchronizer stage
   assign idx_fall = idx_prev_q & ~idx_sync_q;

   // Index synchronizer and previous-value register, both idle high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_sync_q <= 1'b1;
         idx_prev_q <= 1'b1;
      end else begin
         idx_sync_q <= fd_index_i;
         idx_prev_q <= idx_sync_q;
      end
   end

   // Track-zero flag follows the drive track every cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         track0_q <= 1'b0;
      end else begin
         track0_q <= (fd_track_i == 8'd0);
      end
   end

   // Decide whether the latched command is finished and which way to step
   always_comb begin
      cmp_done = 1'b0;
      cmp_out  = 1'b0;
      case (op_q)
         c_op_restore: begin
            cmp_done = (fd_track_i == 8'd0);
            cmp_out  = 1'b0;
         end
         c_op_seek: begin
            cmp_done = (target_q == fd_track_i);
            cmp_out  = (target_q > fd_track_i);
         end
         c_op_step_in: begin
            cmp_done = stepped_q;
            cmp_out  = 1'b0;
         end
         default: begin
            cmp_done = stepped_q;
            cmp_out  = 1'b1;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         op_q        <= 2'd0;
         target_q    <= 8'd0;
         dir_out_q   <= 1'b0;
         step_cnt_q  <= 8'd0;
         tmo_q       <= 24'd0;
         pulse_cnt_q <= '0;
         dwell_q     <= 1'b0;
         armed_q     <= 1'b0;
         stepped_q   <= 1'b0;
         motor_q     <= 1'b0;
         seek_err_q  <= 1'b0;
         not_ready_q <= 1'b0;
         idx_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         target_q    <= target_d;
         dir_out_q   <= dir_out_d;
         step_cnt_q  <= step_cnt_d;
         tmo_q       <= tmo_d;
         pulse_cnt_q <= pulse_cnt_d;
         dwell_q     <= dwell_d;
         armed_q     <= armed_d;
         stepped_q   <= stepped_d;
         motor_q     <= motor_d;
         seek_err_q  <= seek_err_d;
         not_ready_q <= not_ready_d;
         idx_cnt_q   <= idx_cnt_d;
      end
   end

   // Next-state logic for the command sequencer and idle motor timer
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      target_d    = target_q;
      dir_out_d   = dir_out_q;
      step_cnt_d  = step_cnt_q;
      tmo_d       = tmo_q;
      pulse_cnt_d = pulse_cnt_q;
      dwell_d     = dwell_q;
      armed_d     = armed_q;
      stepped_d   = stepped_q;
      motor_d     = motor_q;
      seek_err_d  = seek_err_q;
      not_ready_d = not_ready_q;
      idx_cnt_d   = idx_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               op_d        = cmd_op_i;
               target_d    = cmd_target_i;
               seek_err_d  = 1'b0;
               not_ready_d = 1'b0;
               motor_d     = 1'b1;
               step_cnt_d  = 8'd0;
               tmo_d       = 24'd0;
               stepped_d   = 1'b0;
               idx_cnt_d   = '0;
               state_d     = S_SPINUP;
            end else if (idx_fall && motor_q) begin
               // Count index revolutions while idle; shut the spindle off
               // once enough have passed without a new command.
               if (idx_cnt_q == c_idx_last) begin
                  motor_d   = 1'b0;
                  idx_cnt_d = '0;
               end else begin
                  idx_cnt_d = idx_cnt_q + 1'b1;
               end
            end
         end

         S_SPINUP: begin
            if (fd_ready_i) begin
               state_d = S_COMPARE;
            end else if (tmo_q == READY_TIMEOUT) begin
               not_ready_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               tmo_d = tmo_q + 24'd1;
            end
         end

         S_COMPARE: begin
            if (cmp_done) begin
               state_d = S_DONE;
            end else if (step_cnt_q == c_max_steps) begin
               // Head never reached the target (e.g. track saturated)
               seek_err_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               dir_out_d   = cmp_out;
               pulse_cnt_d = '0;
               state_d     = S_PULSE;
            end
         end

         S_PULSE: begin
            if (pulse_cnt_q == c_pulse_last) begin
               step_cnt_d  = (step_cnt_q == 8'hFF) ? 8'hFF : step_cnt_q + 8'd1;
               tmo_d       = 24'd0;
               stepped_d   = 1'b1;
               dwell_d     = 1'b0;
               armed_d     = 1'b0;
               state_d     = S_SETTLE;
            end else begin
               pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
         end

         S_SETTLE: begin
            // Only trust ready once the drive has shown not-ready, or after
            // a two-cycle dwell, so a stale ready level is not taken as settled.
            if (armed_q && fd_ready_i) begin
               state_d = S_COMPARE;
            end else begin
               if (!fd_ready_i || dwell_q) begin
                  armed_d = 1'b1;
               end
               dwell_d = 1'b1;
               if (tmo_q == READY_TIMEOUT) begin
                  not_ready_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  tmo_d = tmo_q + 24'd1;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode; step lines are only ever active in PULSE, one at a time
   assign step_in_o   = (state_q == S_PULSE) && !dir_out_q;
   assign step_out_o  = (state_q == S_PULSE) &&  dir_out_q;
   assign cmd_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign motor_on_o  = motor_q;
   assign track0_o    = track0_q;
   assign seek_err_o  = seek_err_q;
   assign not_ready_o = not_ready_q;

endmodule
`default_nettype wire
